melody_sequencer: RTL and testbench

- Note-sequencing stage directly upstream of the tone prescale decoder.
- Plays one of two built-in melodies from an internal note ROM.
- Drives a 4-bit tone index (0-15, same index space the decoder consumes) and a sound enable, each for a programmed number of beats, with a short silent gap between notes.
- Used for game jingles such as intro and death; started by a one-cycle pulse from game control.

---
 rtl/melody_sequencer.sv | 167 ++++++++++++++++
 tb/tb_melody_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Plays one of two built-in jingles as {tone, enable_sound} steps; optional restart-while-busy
// is compiled in with MELODY_RESTART_EN.
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | fetch ROM entry at index
//   PLAY  | note (or rest) sounding for max(dur,1) beats
//   GAP   | silent spacer before next note
//   DONE  | one-cycle completion pulse
module melody_sequencer #(
    parameter int BEAT_CYCLES = 3_937_500,
    parameter int GAP_CYCLES  = 315_000,
    parameter int MAX_NOTES   = 32
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    input  logic       melody_sel,
    input  logic       stop,
    output logic [3:0] tone,
    output logic       enable_sound,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(15 * BEAT_CYCLES + 1);
    localparam int IW = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_DONE} state_t;

    // Entry layout: {end, rest, dur[3:0], tone[3:0]}
    function automatic logic [9:0] rom_entry(input logic sel, input logic [IW-1:0] idx);
        logic [9:0] e;
        e = {1'b1, 1'b1, 4'd0, 4'd0};
        if (!sel) begin
            case (idx)
                IW'(0):  e = {1'b0, 1'b0, 4'd2, 4'd0};
                IW'(1):  e = {1'b0, 1'b0, 4'd2, 4'd4};
                IW'(2):  e = {1'b0, 1'b1, 4'd1, 4'd0};
                IW'(3):  e = {1'b1, 1'b0, 4'd4, 4'd12};
                default: e = {1'b1, 1'b1, 4'd0, 4'd0};
            endcase
        end else begin
            case (idx)
                IW'(0):  e = {1'b0, 1'b0, 4'd1, 4'd9};
                IW'(1):  e = {1'b0, 1'b0, 4'd0, 4'd9};
                IW'(2):  e = {1'b1, 1'b0, 4'd3, 4'd15};
                default: e = {1'b1, 1'b1, 4'd0, 4'd0};
            endcase
        end
        return e;
    endfunction

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            sel_q, sel_d;
    logic [5:0]      entry_q, entry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      tone_q, tone_d;
    logic            en_q, en_d;
    logic            done_q, done_d;

    logic [9:0]      rom_word;
    logic [3:0]      dur_eff;
    logic [CW-1:0]   play_len;
    logic            play_last;
    logic            gap_last;

    assign rom_word  = rom_entry(sel_q, idx_q);
    assign dur_eff   = (entry_q[3:0] == 4'd0) ? 4'd1 : entry_q[3:0];
    assign play_len  = CW'(dur_eff) * CW'(BEAT_CYCLES);
    assign play_last = (cnt_q == play_len - CW'(1));
    assign gap_last  = (cnt_q == CW'(GAP_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        entry_d = entry_q;
        cnt_d   = '0;
        tone_d  = tone_q;
        en_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_LOAD;
                    sel_d   = melody_sel;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                state_d = S_PLAY;
                entry_d = rom_word[9:4];
                tone_d  = rom_word[3:0];
                en_d    = !rom_word[8];
            end
            S_PLAY: begin
                if (play_last) begin
                    if (entry_q[5] || (idx_q == IW'(MAX_NOTES - 1))) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    en_d  = !entry_q[4];
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    state_d = S_LOAD;
                    idx_d   = idx_q + IW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef MELODY_RESTART_EN
        if ((state_q != S_IDLE) && start && !stop) begin
            state_d = S_LOAD;
            idx_d   = '0;
            sel_d   = melody_sel;
            cnt_d   = '0;
            en_d    = 1'b0;
            done_d  = 1'b0;
        end
`endif
        // stop wins over everything, including a restart in the same cycle
        if ((state_q != S_IDLE) && stop) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            en_d    = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            sel_q   <= 1'b0;
            entry_q <= '0;
            cnt_q   <= '0;
            tone_q  <= 4'd0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            tone_q  <= tone_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    assign tone         = tone_q;
    assign enable_sound = en_q;
    assign done         = done_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with BEAT_CYCLES=10, GAP_CYCLES=2; cycle-by-cycle
// timeline checks against hand-derived note windows.
module tb_melody_sequencer;

    logic       clk = 1'b0;
    logic       resetN;
    logic       start;
    logic       melody_sel;
    logic       stop;
    logic [3:0] tone;
    logic       enable_sound;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    int nseg;
    int seg_lo [6];
    int seg_hi [6];
    int seg_tn [6];
    int done_cyc;
    int busy_last;
    int inj_cyc;
    logic inj_sel;
    int stop_cyc;

    melody_sequencer #(
        .BEAT_CYCLES(10),
        .GAP_CYCLES (2),
        .MAX_NOTES  (32)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .start       (start),
        .melody_sel  (melody_sel),
        .stop        (stop),
        .tone        (tone),
        .enable_sound(enable_sound),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    // Start in cycle 0, then check every cycle 1..last_cyc against the segment table.
    task automatic run(input logic sel, input int last_cyc);
        logic exp_en;
        logic [3:0] exp_tn;
        melody_sel = sel;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= last_cyc; c++) begin
            exp_en = 1'b0;
            exp_tn = 4'd0;
            for (int s = 0; s < nseg; s++) begin
                if (c >= seg_lo[s] && c <= seg_hi[s]) begin
                    exp_en = 1'b1;
                    exp_tn = 4'(seg_tn[s]);
                end
            end
            chk("enable_sound", c, {7'd0, enable_sound}, {7'd0, exp_en});
            chk("busy", c, {7'd0, busy}, {7'd0, (c <= busy_last)});
            chk("done", c, {7'd0, done}, {7'd0, (c == done_cyc)});
            if (exp_en) chk("tone", c, {4'd0, tone}, {4'd0, exp_tn});
            if (c == inj_cyc) begin
                start = 1'b1;
                melody_sel = inj_sel;
            end
            if (c == stop_cyc) stop = 1'b1;
            step();
            start = 1'b0;
            stop = 1'b0;
        end
    endtask

    task automatic set_m0();
        nseg = 3;
        seg_lo[0] = 2;  seg_hi[0] = 21;  seg_tn[0] = 0;
        seg_lo[1] = 25; seg_hi[1] = 44;  seg_tn[1] = 4;
        seg_lo[2] = 61; seg_hi[2] = 100; seg_tn[2] = 12;
        done_cyc = 101; busy_last = 101; inj_cyc = -1; inj_sel = 1'b0; stop_cyc = -1;
    endtask

    initial begin
        resetN = 1'b0;
        start = 1'b1;
        melody_sel = 1'b0;
        stop = 1'b0;

        // reset held with start asserted
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_tone", i, {4'd0, tone}, 8'd0);
            chk("rst_en", i, {7'd0, enable_sound}, 8'd0);
            chk("rst_busy", i, {7'd0, busy}, 8'd0);
            chk("rst_done", i, {7'd0, done}, 8'd0);
        end
        start = 1'b0;
        resetN = 1'b1;
        step();
        chk("post_rst_busy", 0, {7'd0, busy}, 8'd0);
        step();

        // melody 0 full run
        set_m0();
        run(1'b0, 104);
        step();

        // melody 1, dur=0 plays as one beat
        nseg = 3;
        seg_lo[0] = 2;  seg_hi[0] = 11; seg_tn[0] = 9;
        seg_lo[1] = 15; seg_hi[1] = 24; seg_tn[1] = 9;
        seg_lo[2] = 28; seg_hi[2] = 57; seg_tn[2] = 15;
        done_cyc = 58; busy_last = 58; inj_cyc = -1; stop_cyc = -1;
        run(1'b1, 60);
        step();

        // stop during melody 1
        nseg = 1;
        seg_lo[0] = 2; seg_hi[0] = 5; seg_tn[0] = 9;
        done_cyc = -1; busy_last = 5; inj_cyc = -1; stop_cyc = 5;
        run(1'b1, 70);
        chk("stop_tone_hold", 70, {4'd0, tone}, 8'd9);
        step();

        // start and stop together in IDLE
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("ss_busy", 1, {7'd0, busy}, 8'd0);
        step();
        chk("ss_busy2", 2, {7'd0, busy}, 8'd0);
        chk("ss_en", 2, {7'd0, enable_sound}, 8'd0);

        // start in cycle 30 of melody 0
        set_m0();
        inj_cyc = 30;
        inj_sel = 1'b1;
`ifdef MELODY_RESTART_EN
        nseg = 5;
        seg_hi[1] = 30;
        seg_lo[2] = 32; seg_hi[2] = 41; seg_tn[2] = 9;
        seg_lo[3] = 45; seg_hi[3] = 54; seg_tn[3] = 9;
        seg_lo[4] = 58; seg_hi[4] = 87; seg_tn[4] = 15;
        done_cyc = 88; busy_last = 88;
`endif
        run(1'b0, 104);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
